aec_stall_sequencer: RTL and testbench
======================================

Name: aec_stall_sequencer

Overview:
- Sits between the 6502 core bus and the 6502-to-7501 bus adapter.
- Converts the TED's AEC bus-steal into a 6502 RDY stall.
- The NMOS 6502 ignores RDY during write cycles (e.g. BRK/IRQ stack pushes), so writes issued while the bus is stolen are posted into a small FIFO. They are replayed on the 7501 side once AEC returns; RDY is released only after that.
- Also produces the R/W seen by the 7501 side, optionally gated by gate_in.

Parameters:
- DEPTH, 3, write-post FIFO entries (3 covers the longest 6502 write burst).
- CW, 2, width of fifo_count; must satisfy 2^CW > DEPTH.

Ports:
- clock  input  1  system phi2 clock; all state updates on its falling edge.
- _reset  input  1  asynchronous, active-low reset.
- aec  input  1  1 = CPU side owns bus, 0 = TED stealing bus.
- gate_in  input  1  7501 GATE IN; R/W hold strobe.
- r_w_6502  input  1  core R/W (1 = read).
- address_6502  input  16  core address.
- data_6502  input  8  core write data.
- rdy_6502  output  1  to core RDY; 0 = stall.
- r_w_gated  output  1  R/W for the adapter during normal cycles.
- replay_active  output  1  1 while a posted write is driven on the 7501 side.
- replay_address  output  16  address of the write being replayed.
- replay_data  output  8  data of the write being replayed.
- fifo_count  output  CW  posted writes pending.
- overflow  output  1  sticky; a posted write was dropped.

Behaviour:
- Clocking and reset:
  - All registers update on the negedge of clock; _reset is asynchronous.
  - Reset values: rdy_6502=1, replay_active=0, replay_address=0, replay_data=0, fifo_count=0, overflow=0, state=RUN, FIFO pointers=0.
- States: RUN, STALL, REPLAY, RESUME.
- RUN:
  - rdy_6502=1.
  - aec sampled 0 at a clock fall → STALL, and rdy_6502<=0 at that same edge.
  - The cycle in which aec was sampled low is not posted.
- STALL:
  - rdy_6502=0.
  - Each clock fall with r_w_6502=0 pushes {address_6502, data_6502}.
  - Read cycles push nothing; the core is frozen on them.
  - aec sampled 1: fifo_count>0 → REPLAY; fifo_count==0 → RESUME.
- REPLAY:
  - rdy_6502=0 and replay_active=1.
  - replay_address/replay_data show the FIFO head (first-in first-out).
  - Each clock fall with aec=1 pops one entry; pop of the last entry → RESUME.
  - aec sampled 0 during REPLAY: the head is not popped, replay_active<=0, → STALL. Entries remain queued.
- RESUME:
  - One cycle with rdy_6502=0 and replay_active=0, giving the bus turnaround.
  - Then → RUN with rdy_6502<=1.
  - aec sampled 0 during RESUME → STALL.
- Push arithmetic:
  - The FIFO is a circular buffer with wrap-around pointers.
  - Push while fifo_count==DEPTH: entry dropped, overflow<=1 (sticky until reset), count unchanged.
  - Push and pop never coincide, since pushes occur only in STALL.
- r_w_gated: forced to 1 whenever replay_active=1 or aec=0; otherwise per the optional feature below.
- Reset mid-replay: the FIFO is discarded, and the state returns to RUN with rdy_6502=1.

Optional Feature:
- Macro: RW_GATE_LATCH_EN.
- Defined:
  - A hold register captures r_w_6502 at each clock fall where gate_in=1.
  - r_w_gated = gate_in ? r_w_6502 : hold. This emulates the 7501 GATE IN R/W latch, so R/W stays stable through the phi2-low phase.
  - Hold resets to 1.
- Undefined:
  - r_w_gated = r_w_6502, subject to the forcing rule above.
  - gate_in is unused.

Test Plan:
- Reset, then aec=1 with core reads → rdy_6502=1, fifo_count=0, r_w_gated tracks r_w_6502.
- aec=0 for 4 clocks with core reading → rdy_6502=0 from the first edge. No pushes. After aec=1: one RESUME cycle, then rdy_6502=1; replay_active never asserts.
- aec=0 while core writes $01FF=$12, $01FE=$34, $01FD=$56 → fifo_count=3. After aec=1, replay in 3 cycles in order: $01FF/$12, $01FE/$34, $01FD/$56. Then RESUME, then rdy_6502=1; overflow=0.
- 4 writes during a stall with DEPTH=3 → 4th dropped, overflow=1 and stays 1 after the replay; only the first 3 entries replay.
- 2 posted writes, aec drops after the 1st replay pop → replay_active=0, fifo_count=1. After aec returns, the 2nd entry replays, then RESUME.
- With RW_GATE_LATCH_EN: r_w_6502 toggles 0→1 while gate_in=0 → r_w_gated stays 0 until gate_in=1. Without the macro, r_w_gated follows immediately.

Source files
------------

// File: rtl/aec_stall_sequencer.sv
// Turns the TED's AEC bus-steal into a 6502 RDY stall, posting core writes made while the bus is
// stolen and replaying them once AEC returns. Optional macro: RW_GATE_LATCH_EN (GATE IN R/W latch).
module aec_stall_sequencer #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = 2
) (
  input  logic          clock,
  input  logic          _reset,
  input  logic          aec,
  input  logic          gate_in,
  input  logic          r_w_6502,
  input  logic [15:0]   address_6502,
  input  logic [7:0]    data_6502,
  output logic          rdy_6502,
  output logic          r_w_gated,
  output logic          replay_active,
  output logic [15:0]   replay_address,
  output logic [7:0]    replay_data,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StRun, StStall, StReplay, StResume} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     addr_mem_q [DEPTH];
  logic [7:0]      data_mem_q [DEPTH];

  logic push, push_ok, pop, full;
  logic r_w_sel;

  assign full    = (count_q == CW'(DEPTH));
  assign push    = (state_q == StStall) && !r_w_6502;
  assign push_ok = push && !full;
  assign pop     = (state_q == StReplay) && aec;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);

    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (push && full) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    unique case (state_q)
      StRun: begin
        if (!aec) state_d = StStall;
      end
      StStall: begin
        // Decide on the post-push count so a write landing on the release edge is not lost.
        if (aec) state_d = (count_d != '0) ? StReplay : StResume;
      end
      StReplay: begin
        if (!aec) begin
          state_d = StStall;
        end else if (count_q == CW'(1)) begin
          state_d = StResume;
        end
      end
      StResume: begin
        state_d = aec ? StRun : StStall;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(negedge clock) begin
    if (push_ok) begin
      addr_mem_q[wr_ptr_q] <= address_6502;
      data_mem_q[wr_ptr_q] <= data_6502;
    end
  end

`ifdef RW_GATE_LATCH_EN
  logic hold_q;

  always_ff @(negedge clock or negedge _reset) begin
    if (!_reset) begin
      hold_q <= 1'b1;
    end else if (gate_in) begin
      hold_q <= r_w_6502;
    end
  end

  assign r_w_sel = gate_in ? r_w_6502 : hold_q;
`else
  logic unused_gate_in;

  assign unused_gate_in = gate_in;
  assign r_w_sel        = r_w_6502;
`endif

  assign rdy_6502       = (state_q == StRun);
  assign replay_active  = (state_q == StReplay);
  assign replay_address = replay_active ? addr_mem_q[rd_ptr_q] : 16'h0000;
  assign replay_data    = replay_active ? data_mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  // Read level whenever the adapter side is not driven by the core.
  assign r_w_gated      = (replay_active || !aec) ? 1'b1 : r_w_sel;

endmodule

// File: tb/tb_aec_stall_sequencer.sv
// Directed bench for aec_stall_sequencer: a scoreboard queue holds expected replayed writes and a
// monitor process checks each one as the DUT presents it.
module tb_aec_stall_sequencer;

  logic        clock;
  logic        _reset;
  logic        aec;
  logic        gate_in;
  logic        r_w_6502;
  logic [15:0] address_6502;
  logic [7:0]  data_6502;
  logic        rdy_6502;
  logic        r_w_gated;
  logic        replay_active;
  logic [15:0] replay_address;
  logic [7:0]  replay_data;
  logic [1:0]  fifo_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [23:0] sb [$];

  aec_stall_sequencer #(.DEPTH(3), .CW(2)) dut (
    .clock         (clock),
    ._reset        (_reset),
    .aec           (aec),
    .gate_in       (gate_in),
    .r_w_6502      (r_w_6502),
    .address_6502  (address_6502),
    .data_6502     (data_6502),
    .rdy_6502      (rdy_6502),
    .r_w_gated     (r_w_gated),
    .replay_active (replay_active),
    .replay_address(replay_address),
    .replay_data   (replay_data),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Drive inputs for the next falling edge; return at a quiet sample point before it.
  task automatic step(input logic a, input logic rw, input logic [15:0] ad, input logic [7:0] d);
    @(posedge clock);
    #1;
    aec          = a;
    r_w_6502     = rw;
    address_6502 = ad;
    data_6502    = d;
    #1;
  endtask

  task automatic post(input logic [15:0] ad, input logic [7:0] d, input bit keep);
    step(1'b0, 1'b0, ad, d);
    if (keep) sb.push_back({ad, d});
  endtask

  // Monitor: each replay cycle that will pop (aec high) must present the scoreboard head.
  initial begin
    logic [23:0] exp;
    forever begin
      @(posedge clock);
      #2;
      if (_reset && replay_active && aec) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL replay_unexpected got %0h/%0h expected none at %0t",
                   replay_address, replay_data, $time);
        end else begin
          exp = sb.pop_front();
          chk("replay_addr", 32'(replay_address), 32'(exp[23:8]));
          chk("replay_data", 32'(replay_data), 32'(exp[7:0]));
        end
      end
    end
  end

  initial begin
    aec = 1'b1; gate_in = 1'b1; r_w_6502 = 1'b1; address_6502 = '0; data_6502 = '0;
    _reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    chk("rst_rdy", 32'(rdy_6502), 1);
    chk("rst_active", 32'(replay_active), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_addr", 32'(replay_address), 0);
    chk("rst_data", 32'(replay_data), 0);
    @(posedge clock);
    #1 _reset = 1'b1;

    // Normal reads/writes with the bus owned by the core
    step(1'b1, 1'b1, 16'h1000, 8'h00);
    chk("run_rw_read", 32'(r_w_gated), 1);
    chk("run_rdy", 32'(rdy_6502), 1);
    step(1'b1, 1'b0, 16'h1234, 8'hAA);
    chk("run_rw_write", 32'(r_w_gated), 0);
    chk("run_count", 32'(fifo_count), 0);

    // Read-only stall
    step(1'b0, 1'b0, 16'h1234, 8'hAA);
    chk("aec_low_rw_forced", 32'(r_w_gated), 1);
    chk("pre_edge_rdy", 32'(rdy_6502), 1);
    step(1'b0, 1'b1, 16'h2000, 8'h00);
    chk("stall_rdy", 32'(rdy_6502), 0);
    chk("stall_count", 32'(fifo_count), 0);
    step(1'b0, 1'b1, 16'h2000, 8'h00);
    step(1'b0, 1'b1, 16'h2000, 8'h00);
    step(1'b1, 1'b1, 16'h2000, 8'h00);
    chk("release_rdy", 32'(rdy_6502), 0);
    step(1'b1, 1'b1, 16'h2000, 8'h00);
    chk("resume_rdy", 32'(rdy_6502), 0);
    chk("resume_active", 32'(replay_active), 0);
    step(1'b1, 1'b1, 16'h2000, 8'h00);
    chk("rerun_rdy", 32'(rdy_6502), 1);

    // Three posted stack writes replayed in order
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    post(16'h01FF, 8'h12, 1'b1);
    post(16'h01FE, 8'h34, 1'b1);
    post(16'h01FD, 8'h56, 1'b1);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("posted_count", 32'(fifo_count), 3);
    chk("posted_rdy", 32'(rdy_6502), 0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("replay1_active", 32'(replay_active), 1);
    step(1'b1, 1'b0, 16'h3000, 8'h00);
    chk("replay_rw_forced", 32'(r_w_gated), 1);
    chk("replay2_count", 32'(fifo_count), 2);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("post_replay_active", 32'(replay_active), 0);
    chk("post_replay_rdy", 32'(rdy_6502), 0);
    chk("post_replay_count", 32'(fifo_count), 0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("after3_rdy", 32'(rdy_6502), 1);
    chk("after3_ovf", 32'(overflow), 0);

    // Overflow: fourth write dropped
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    post(16'h0200, 8'hA1, 1'b1);
    post(16'h0201, 8'hA2, 1'b1);
    post(16'h0202, 8'hA3, 1'b1);
    post(16'h0203, 8'hA4, 1'b0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("ovf_count", 32'(fifo_count), 3);
    chk("ovf_flag", 32'(overflow), 1);
    repeat (3) step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("ovf_resume_rdy", 32'(rdy_6502), 0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("ovf_run_rdy", 32'(rdy_6502), 1);
    chk("ovf_sticky", 32'(overflow), 1);

    // AEC drops mid-replay
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    post(16'h0300, 8'h11, 1'b1);
    post(16'h0301, 8'h22, 1'b1);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("int_count", 32'(fifo_count), 2);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    chk("int_head_shown", 32'(replay_address), 32'h0301);
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    chk("int_active", 32'(replay_active), 0);
    chk("int_left", 32'(fifo_count), 1);
    chk("int_rdy", 32'(rdy_6502), 0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("int_replay2", 32'(replay_active), 1);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("int_resume", 32'(replay_active), 0);
    chk("int_resume_rdy", 32'(rdy_6502), 0);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("int_run_rdy", 32'(rdy_6502), 1);

    // GATE IN R/W latch behaviour
    step(1'b1, 1'b0, 16'h4000, 8'h00);
    @(posedge clock);
    #1 gate_in = 1'b0; r_w_6502 = 1'b1;
    #1;
`ifdef RW_GATE_LATCH_EN
    chk("gate_hold", 32'(r_w_gated), 0);
`else
    chk("gate_follow", 32'(r_w_gated), 1);
`endif
    @(posedge clock);
    #1 gate_in = 1'b1;
    #1;
    chk("gate_open", 32'(r_w_gated), 1);

    // Reset during replay discards the FIFO
    step(1'b0, 1'b1, 16'h3000, 8'h00);
    post(16'h0400, 8'h77, 1'b1);
    post(16'h0401, 8'h88, 1'b1);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    #1 _reset = 1'b0;
    #1;
    chk("mid_rst_rdy", 32'(rdy_6502), 1);
    chk("mid_rst_active", 32'(replay_active), 0);
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    sb.delete();
    @(posedge clock);
    #1 _reset = 1'b1;
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("post_rst_rdy", 32'(rdy_6502), 1);
    chk("post_rst_count", 32'(fifo_count), 0);

    step(1'b1, 1'b1, 16'h3000, 8'h00);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
